// File: rtl/writeback_stage.sv
// writeback_stage
//   Selects the writeback value for a retiring instruction (upper immediate,
//   ALU result, return address or an extracted and extended load) and queues
//   it in a small FIFO that feeds the register file write port.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   clk_enable           global stall; low freezes every piece of state
//   in_valid/in_ready    producer handshake (in_ready depends on occupancy only)
//   in_sel               000 UPPER, 001 ALU, 010 RET_ADDR, 011 LOAD
//   in_rd                destination register index
//   in_upper_imm, in_alu, in_ret_addr, in_load_data, in_load_mode, in_load_off
//                        candidate result sources and load extraction controls
//   out_valid/out_ready  register file handshake
//   out_data, out_rd     head entry, zero while the buffer is empty
//   out_we               head entry targets a register other than x0
//   count                buffer occupancy
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int RD_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_enable,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_sel,
  input  logic [RD_W-1:0]        in_rd,
  input  logic [XLEN-1:0]        in_upper_imm,
  input  logic [XLEN-1:0]        in_alu,
  input  logic [XLEN-3:0]        in_ret_addr,
  input  logic [31:0]            in_load_data,
  input  logic [2:0]             in_load_mode,
  input  logic [1:0]             in_load_off,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_data,
  output logic [RD_W-1:0]        out_rd,
  output logic                   out_we,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Byte/halfword/word extraction with sign or zero extension to XLEN.
  // Size casts of the signed locals sign-extend; casts of raw slices zero-extend.
  function automatic logic [XLEN-1:0] extract_load(input logic [31:0] word,
                                                   input logic [2:0]  mode,
                                                   input logic [1:0]  off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [XLEN-1:0]    r;
    b = $signed(word[{off, 3'b000} +: 8]);
    h = $signed(word[{off[1], 4'b0000} +: 16]);
    w = $signed(word);
    case (mode)
      3'b000:  r = XLEN'(b);
      3'b001:  r = XLEN'(h);
      3'b010:  r = XLEN'(w);
      3'b100:  r = XLEN'($unsigned(b));
      3'b101:  r = XLEN'($unsigned(h));
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] select_result(input logic [2:0]      sel,
                                                    input logic [XLEN-1:0] upper,
                                                    input logic [XLEN-1:0] alu,
                                                    input logic [XLEN-3:0] ret,
                                                    input logic [XLEN-1:0] load);
    logic [XLEN-1:0] r;
    case (sel)
      3'b000:  r = upper;
      3'b001:  r = alu;
      3'b010:  r = {ret, 2'b00};
      3'b011:  r = load;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [XLEN-1:0] data_mem [DEPTH];
  logic [RD_W-1:0] rd_mem   [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] result_p0;

  // Stage p0: result formation and handshake decode (combinational at accept)
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & clk_enable;
  assign pop       = out_valid & out_ready & clk_enable;
  assign result_p0 = select_result(in_sel, in_upper_imm, in_alu, in_ret_addr,
                                   extract_load(in_load_data, in_load_mode, in_load_off));

  // Stage p1: buffer state; the head is visible only while occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clk_enable) begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= result_p0;
      rd_mem[wr_ptr]   <= in_rd;
    end
  end

  assign out_data = out_valid ? data_mem[rd_ptr] : '0;
  assign out_rd   = out_valid ? rd_mem[rd_ptr]   : '0;
  assign out_we   = out_valid && (out_rd != '0);

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int RD_W  = 5;

  logic             clk;
  logic             rst_n;
  logic             clk_enable;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_sel;
  logic [RD_W-1:0]  in_rd;
  logic [XLEN-1:0]  in_upper_imm;
  logic [XLEN-1:0]  in_alu;
  logic [XLEN-3:0]  in_ret_addr;
  logic [31:0]      in_load_data;
  logic [2:0]       in_load_mode;
  logic [1:0]       in_load_off;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [RD_W-1:0]  out_rd;
  logic             out_we;
  logic [1:0]       count;

  writeback_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_rd(in_rd),
    .in_upper_imm(in_upper_imm), .in_alu(in_alu), .in_ret_addr(in_ret_addr),
    .in_load_data(in_load_data), .in_load_mode(in_load_mode), .in_load_off(in_load_off),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_we(out_we), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } ent_t;

  ent_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference value from the architectural rules using plain integer arithmetic.
  function automatic logic [31:0] model_result();
    longint w, v;
    w = longint'(in_load_data);
    v = 0;
    case (in_sel)
      3'd0: v = longint'(in_upper_imm);
      3'd1: v = longint'(in_alu);
      3'd2: v = longint'(in_ret_addr) * 4;
      3'd3: begin
        case (in_load_mode)
          3'd0: begin v = (w >> (8 * in_load_off)) % 256; if (v >= 128) v = v - 256; end
          3'd1: begin v = (w >> (16 * (in_load_off / 2))) % 65536; if (v >= 32768) v = v - 65536; end
          3'd2: begin v = w; if (v >= 64'sd2147483648) v = v - 64'sd4294967296; end
          3'd4: v = (w >> (8 * in_load_off)) % 256;
          3'd5: v = (w >> (16 * (in_load_off / 2))) % 65536;
          default: v = 0;
        endcase
      end
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic check_model();
    logic        ev;
    logic [31:0] ed;
    logic [4:0]  er;
    ev = (q.size() != 0);
    ed = ev ? q[0].data : 32'd0;
    er = ev ? q[0].rd : 5'd0;
    check("out_valid", 64'(out_valid), 64'(ev));
    check("out_data",  64'(out_data),  64'(ed));
    check("out_rd",    64'(out_rd),    64'(er));
    check("out_we",    64'(out_we),    64'(ev && er != 0));
    check("count",     64'(count),     64'(q.size()));
    check("in_ready",  64'(in_ready),  64'(q.size() < DEPTH));
  endtask

  // One clock: decide accept/pop from the inputs and model occupancy, then compare.
  task automatic tick();
    logic acc, pp;
    ent_t e;
    acc    = in_valid && (q.size() < DEPTH) && clk_enable;
    pp     = (q.size() != 0) && out_ready && clk_enable;
    e.data = model_result();
    e.rd   = in_rd;
    @(posedge clk);
    #1;
    if (pp)  void'(q.pop_front());
    if (acc) q.push_back(e);
    check_model();
  endtask

  task automatic offer(input logic [2:0] sel, input logic [4:0] rd, input logic [31:0] v);
    in_valid     = 1'b1;
    in_sel       = sel;
    in_rd        = rd;
    in_upper_imm = v;
    in_alu       = v;
    in_ret_addr  = v[29:0];
    in_load_data = v;
  endtask

  task automatic load(input logic [2:0] mode, input logic [1:0] off, input logic [31:0] word);
    offer(3'd3, 5'd7, word);
    in_load_mode = mode;
    in_load_off  = off;
  endtask

  initial begin
    rst_n = 1'b0; clk_enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sel = '0; in_rd = '0; in_upper_imm = '0; in_alu = '0; in_ret_addr = '0;
    in_load_data = '0; in_load_mode = '0; in_load_off = '0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count",     64'(count),     64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_we",    64'(out_we),    64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Return address, observed the cycle after accept
    out_ready = 1'b1;
    offer(3'd2, 5'd1, 32'h0000_0401);
    tick();
    check("ret_data", 64'(out_data), 64'h0000_1004);
    check("ret_we",   64'(out_we),   64'd1);

    // Load extraction cases
    load(3'd0, 2'd0, 32'h8000_7F80); tick();
    check("lb_off0",  64'(out_data), 64'hFFFF_FF80);
    load(3'd4, 2'd3, 32'h8000_7F80); tick();
    check("lbu_off3", 64'(out_data), 64'h0000_0080);
    load(3'd1, 2'd2, 32'h8000_7F80); tick();
    check("lh_off2",  64'(out_data), 64'hFFFF_8000);
    load(3'd5, 2'd1, 32'h8000_7F80); tick();
    check("lhu_off1", 64'(out_data), 64'h0000_7F80);
    load(3'd3, 2'd0, 32'h8000_7F80); tick();
    check("ld_rsvd",  64'(out_data), 64'd0);

    // x0 destination suppresses the write enable
    offer(3'd1, 5'd0, 32'hDEAD_BEEF); tick();
    check("x0_valid", 64'(out_valid), 64'd1);
    check("x0_data",  64'(out_data),  64'hDEAD_BEEF);
    check("x0_we",    64'(out_we),    64'd0);
    in_valid = 1'b0; tick();

    // Backpressure: third offer refused while full, then ordered drain
    out_ready = 1'b0;
    offer(3'd0, 5'd3, 32'h1111_1111); tick();
    offer(3'd0, 5'd4, 32'h2222_2222); tick();
    offer(3'd0, 5'd5, 32'h3333_3333);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count",    64'(count),    64'd2);
    tick();
    check("full_hold_data", 64'(out_data), 64'h1111_1111);

    // Stall with full buffer: nothing moves
    clk_enable = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_count", 64'(count), 64'd2);
    end
    clk_enable = 1'b1; in_valid = 1'b0;
    tick();
    check("drain_first", 64'(out_data), 64'h2222_2222);

    // Refill, then reset in the middle of a cycle
    out_ready = 1'b0;
    offer(3'd1, 5'd9, 32'hAAAA_0001); tick();
    offer(3'd1, 5'd10, 32'hAAAA_0002); tick();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_count", 64'(count),     64'd0);
    check("midrst_data",  64'(out_data),  64'd0);
    q.delete();
    #1 rst_n = 1'b1;
    tick();

    // Randomized traffic against the queue model
    for (int c = 0; c < 10000; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 2) != 0);
      clk_enable   = ($urandom_range(0, 7) != 0);
      in_sel       = 3'($urandom_range(0, 7));
      in_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      in_upper_imm = $urandom;
      in_alu       = $urandom;
      in_ret_addr  = 30'($urandom);
      in_load_data = $urandom;
      in_load_mode = 3'($urandom_range(0, 7));
      in_load_off  = 2'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
